// File: rtl/apb_master_pkg.sv
// Shared types and constants for the single-outstanding APB master.
// State encoding, bus widths and default address-space / timeout limits.
package apb_master_pkg;

  localparam int unsigned APB_ADDR_W             = 32;
  localparam int unsigned APB_DATA_W             = 32;
  localparam int unsigned DEFAULT_ADDR_LIMIT     = 60;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;
  localparam int unsigned TMO_CNT_W              = 8;

  typedef logic [APB_ADDR_W-1:0] addr_t;
  typedef logic [APB_DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RDCAP  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // Word-aligned and inside the register file, or the command never reaches APB.
  function automatic logic addr_rejected(input addr_t addr, input addr_t limit);
    return (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Host command/response channels plus the APB bus of the APB master.
// Command and response channels: a beat transfers on the rising edge where valid and ready are both high;
// valid never waits on ready, and payload is held stable while valid is high and ready is low.
interface apb_master_if;
  import apb_master_pkg::*;

  logic  I_CMD_VALID;
  logic  O_CMD_READY;
  logic  I_CMD_WRITE;
  addr_t I_CMD_ADDR;
  data_t I_CMD_WDATA;

  logic  O_RSP_VALID;
  logic  I_RSP_READY;
  data_t O_RSP_RDATA;
  logic  O_RSP_ERR;

  logic  O_PSEL;
  logic  O_PENABLE;
  logic  O_PWRITE;
  addr_t O_PADDR;
  data_t O_PWDATA;
  data_t I_PRDATA;
  logic  I_PREADY;

  modport master (
    input  I_CMD_VALID, I_CMD_WRITE, I_CMD_ADDR, I_CMD_WDATA,
    input  I_RSP_READY, I_PRDATA, I_PREADY,
    output O_CMD_READY, O_RSP_VALID, O_RSP_RDATA, O_RSP_ERR,
    output O_PSEL, O_PENABLE, O_PWRITE, O_PADDR, O_PWDATA
  );

  modport slave (
    output I_CMD_VALID, I_CMD_WRITE, I_CMD_ADDR, I_CMD_WDATA,
    output I_RSP_READY, I_PRDATA, I_PREADY,
    input  O_CMD_READY, O_RSP_VALID, O_RSP_RDATA, O_RSP_ERR,
    input  O_PSEL, O_PENABLE, O_PWRITE, O_PADDR, O_PWDATA
  );

endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: one host command becomes one SETUP/ACCESS transfer,
// with local rejection of illegal addresses and a PREADY timeout on every ACCESS phase.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT     = DEFAULT_ADDR_LIMIT,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic         I_PCLK,
  input  logic         I_PRESET_N,
  apb_master_if.master bus,
  output state_t       O_DBG_STATE
);

  localparam addr_t                LIMIT     = addr_t'(ADDR_LIMIT);
  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES);

  state_t               state_q;
  state_t               state_nxt;
  logic [TMO_CNT_W-1:0] tmo_cnt_q;
  logic [TMO_CNT_W-1:0] tmo_cnt_nxt;
  logic [TMO_CNT_W-1:0] tmo_cnt_inc;

  logic cmd_accept;
  logic cmd_reject;
  logic access_done;
  logic access_abort;

  logic  cmd_ready_d;
  logic  psel_d;
  logic  penable_d;
  logic  pwrite_d;
  addr_t paddr_d;
  data_t pwdata_d;
  logic  rsp_valid_d;
  data_t rsp_rdata_d;
  logic  rsp_err_d;

  // O_CMD_READY is itself a flop, so the first cycle after reset release cannot accept.
  assign cmd_accept   = (state_q == ST_IDLE) && bus.I_CMD_VALID && bus.O_CMD_READY;
  assign cmd_reject   = addr_rejected(bus.I_CMD_ADDR, LIMIT);
  assign access_done  = (state_q == ST_ACCESS) && bus.I_PREADY;
  assign tmo_cnt_inc  = tmo_cnt_q + TMO_CNT_W'(1);
  assign access_abort = (state_q == ST_ACCESS) && !bus.I_PREADY && (tmo_cnt_inc == TMO_LIMIT);

  assign O_DBG_STATE = state_q;

  always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
    if (!I_PRESET_N) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_nxt;
      tmo_cnt_q <= tmo_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    tmo_cnt_nxt = tmo_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          if (cmd_reject) begin
            state_nxt = ST_RESP;
          end else begin
            state_nxt   = ST_SETUP;
            tmo_cnt_nxt = '0;
          end
        end
      end
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.I_PREADY) begin
          state_nxt = bus.O_PWRITE ? ST_RESP : ST_RDCAP;
        end else begin
          tmo_cnt_nxt = tmo_cnt_inc;
          if (access_abort) state_nxt = ST_RESP;
        end
      end
      ST_RDCAP:  state_nxt = ST_RESP;
      ST_RESP:   if (bus.I_RSP_READY) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Every output is a flop loaded from the state being entered, so none sees an input combinationally.
  always_comb begin
    cmd_ready_d = (state_nxt == ST_IDLE);
    psel_d      = (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
    penable_d   = (state_nxt == ST_ACCESS);
    rsp_valid_d = (state_nxt == ST_RESP);
    pwrite_d    = bus.O_PWRITE;
    paddr_d     = bus.O_PADDR;
    pwdata_d    = bus.O_PWDATA;
    rsp_rdata_d = bus.O_RSP_RDATA;
    rsp_err_d   = bus.O_RSP_ERR;

    if (cmd_accept && !cmd_reject) begin
      pwrite_d = bus.I_CMD_WRITE;
      paddr_d  = bus.I_CMD_ADDR;
      pwdata_d = bus.I_CMD_WDATA;
    end
    if ((cmd_accept && cmd_reject) || access_abort) begin
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
    end
    if (access_done && bus.O_PWRITE) begin
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
    end
    // The slave registers PRDATA, so it is only valid in the cycle after the ACCESS handshake.
    if (state_q == ST_RDCAP) begin
      rsp_rdata_d = bus.I_PRDATA;
      rsp_err_d   = 1'b0;
    end
  end

  always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
    if (!I_PRESET_N) begin
      bus.O_CMD_READY <= 1'b0;
      bus.O_PSEL      <= 1'b0;
      bus.O_PENABLE   <= 1'b0;
      bus.O_PWRITE    <= 1'b0;
      bus.O_PADDR     <= '0;
      bus.O_PWDATA    <= '0;
      bus.O_RSP_VALID <= 1'b0;
      bus.O_RSP_RDATA <= '0;
      bus.O_RSP_ERR   <= 1'b0;
    end else begin
      bus.O_CMD_READY <= cmd_ready_d;
      bus.O_PSEL      <= psel_d;
      bus.O_PENABLE   <= penable_d;
      bus.O_PWRITE    <= pwrite_d;
      bus.O_PADDR     <= paddr_d;
      bus.O_PWDATA    <= pwdata_d;
      bus.O_RSP_VALID <= rsp_valid_d;
      bus.O_RSP_RDATA <= rsp_rdata_d;
      bus.O_RSP_ERR   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed latency/error/backpressure/reset cases plus random traffic,
// scored against a word-array model of the register file and the transfer timing rules.
module tb_apb_master;
  import apb_master_pkg::*;

  localparam int TMO    = 4;
  localparam int LIMIT  = 60;
  localparam int NWORDS = 16;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  state_t       dbg_state;
  apb_master_if bus();

  apb_master #(
    .ADDR_LIMIT    (LIMIT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .I_PCLK     (clk),
    .I_PRESET_N (rst_n),
    .bus        (bus),
    .O_DBG_STATE(dbg_state)
  );

  int          total = 0;
  int          bad   = 0;
  logic [32:0] exp_q[$];
  logic [31:0] ref_mem   [NWORDS];
  logic [31:0] slave_mem [NWORDS];
  int          next_waits = 0;
  logic        stuck      = 1'b0;
  int          wait_left  = 0;
  logic        hs_read    = 1'b0;
  logic [31:0] hs_addr    = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // APB slave: handshakes observed on the rising edge, PRDATA/PREADY driven on the falling edge
  always @(posedge clk) begin
    hs_read = 1'b0;
    if (bus.O_PSEL && bus.O_PENABLE && bus.I_PREADY) begin
      if (bus.O_PWRITE) slave_mem[bus.O_PADDR[5:2]] = bus.O_PWDATA;
      else begin
        hs_read = 1'b1;
        hs_addr = bus.O_PADDR;
      end
    end
  end

  always @(negedge clk) begin
    bus.I_PRDATA = hs_read ? slave_mem[hs_addr[5:2]] : $urandom;
    if (bus.O_PSEL && !bus.O_PENABLE) begin
      wait_left    = next_waits;
      bus.I_PREADY = 1'($urandom_range(0, 1));
    end else if (bus.O_PSEL && bus.O_PENABLE) begin
      bus.I_PREADY = !stuck && (wait_left == 0);
      if (wait_left > 0) wait_left--;
    end else begin
      bus.I_PREADY = 1'($urandom_range(0, 1));
    end
  end

  // reference model: expected response, cycles from handshake to RSP_VALID, first PSEL cycle, ACCESS length
  task automatic model(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                       input logic stk, output int e_lat, output int e_first, output int e_acc);
    if ((addr % 4) != 0 || addr >= LIMIT) begin
      exp_q.push_back({1'b1, 32'h0});
      e_lat = 1; e_first = -1; e_acc = 0;
    end else if (stk) begin
      exp_q.push_back({1'b1, 32'h0});
      e_lat = 2 + TMO; e_first = 1; e_acc = TMO;
    end else if (wr) begin
      ref_mem[addr / 4] = wdata;
      exp_q.push_back({1'b0, 32'h0});
      e_lat = 3 + waits; e_first = 1; e_acc = 1 + waits;
    end else begin
      exp_q.push_back({1'b0, ref_mem[addr / 4]});
      e_lat = 4 + waits; e_first = 1; e_acc = 1 + waits;
    end
  endtask

  // driver: one command, then watch the transfer and the response channel cycle by cycle
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic stk, input int hold);
    int e_lat, e_first, e_acc;
    int k, first, acc, busy_rdy, apb_bad, unstable, budget;
    logic first_pen;
    logic [32:0] got, exp;
    model(wr, addr, wdata, waits, stk, e_lat, e_first, e_acc);
    next_waits = waits;
    stuck      = stk;
    @(negedge clk);
    bus.I_CMD_VALID = 1'b1;
    bus.I_CMD_WRITE = wr;
    bus.I_CMD_ADDR  = addr;
    bus.I_CMD_WDATA = wdata;
    bus.I_RSP_READY = 1'b0;
    budget = 0;
    while (!bus.O_CMD_READY && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.O_CMD_READY) begin
      check("cmd_ready_wait", 32'(bus.O_CMD_READY), 32'd1);
      bus.I_CMD_VALID = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(negedge clk);
    bus.I_CMD_VALID = 1'b0;
    bus.I_CMD_WRITE = 1'($urandom_range(0, 1));
    bus.I_CMD_ADDR  = $urandom;
    bus.I_CMD_WDATA = $urandom;
    k = 1; first = -1; acc = 0; busy_rdy = 0; apb_bad = 0; first_pen = 1'b0;
    while (!bus.O_RSP_VALID && k < 64) begin
      if (bus.O_CMD_READY) busy_rdy++;
      if (bus.O_PENABLE && !bus.O_PSEL) apb_bad++;
      if (bus.O_PSEL) begin
        if (first < 0) begin
          first     = k;
          first_pen = bus.O_PENABLE;
        end
        if (bus.O_PADDR !== addr || bus.O_PWRITE !== wr || (wr && bus.O_PWDATA !== wdata)) apb_bad++;
      end
      if (bus.O_PENABLE) acc++;
      @(negedge clk);
      k++;
    end
    check("rsp_latency", k, e_lat);
    check("psel_first", first, e_first);
    check("setup_penable", 32'(first_pen), 32'd0);
    check("access_cycles", acc, e_acc);
    check("apb_fields", apb_bad, 0);
    check("busy_cmd_ready", busy_rdy, 0);
    check("rsp_apb_idle", 32'(bus.O_PSEL | bus.O_PENABLE), 32'd0);
    got = {bus.O_RSP_ERR, bus.O_RSP_RDATA};
    exp = exp_q.pop_front();
    check("rsp_err", 32'(got[32]), 32'(exp[32]));
    check("rsp_rdata", got[31:0], exp[31:0]);
    unstable = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!bus.O_RSP_VALID || {bus.O_RSP_ERR, bus.O_RSP_RDATA} !== got || bus.O_CMD_READY || bus.O_PSEL)
        unstable++;
    end
    if (hold > 0) check("rsp_hold", unstable, 0);
    bus.I_RSP_READY = 1'b1;
    @(negedge clk);
    bus.I_RSP_READY = 1'b0;
    check("rsp_drop", 32'(bus.O_RSP_VALID), 32'd0);
    check("idle_ready", 32'(bus.O_CMD_READY), 32'd1);
    check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    int          sel, waits, hold, quiet;
    logic        wr, stk;
    logic [31:0] addr, v;

    bus.I_CMD_VALID = 1'b0;
    bus.I_CMD_WRITE = 1'b0;
    bus.I_CMD_ADDR  = '0;
    bus.I_CMD_WDATA = '0;
    bus.I_RSP_READY = 1'b0;
    for (int i = 0; i < NWORDS; i++) begin
      v            = $urandom;
      ref_mem[i]   = v;
      slave_mem[i] = v;
    end

    // reset values and READY rising one cycle after release
    #1 rst_n = 1'b0;
    #2;
    check("rst_cmd_ready", 32'(bus.O_CMD_READY), 32'd0);
    check("rst_psel", 32'(bus.O_PSEL | bus.O_PENABLE), 32'd0);
    check("rst_rsp_valid", 32'(bus.O_RSP_VALID), 32'd0);
    check("rst_paddr", bus.O_PADDR, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_edge", 32'(bus.O_CMD_READY), 32'd0);
    @(negedge clk);
    check("ready_after_release", 32'(bus.O_CMD_READY), 32'd1);

    // directed cases
    run_cmd(1'b1, 32'h08, 32'hDEADBEEF, 0, 1'b0, 0);
    run_cmd(1'b0, 32'h08, 32'h0, 0, 1'b0, 0);
    run_cmd(1'b0, 32'h3C, 32'h0, 0, 1'b0, 0);
    check("paddr_hold", bus.O_PADDR, 32'h08);
    run_cmd(1'b1, 32'h05, 32'h12345678, 0, 1'b0, 0);
    run_cmd(1'b0, 32'h00, 32'h0, 0, 1'b1, 0);
    run_cmd(1'b0, 32'h10, 32'h0, 0, 1'b0, 5);
    run_cmd(1'b1, 32'h38, 32'hCAFEF00D, 3, 1'b0, 1);
    run_cmd(1'b0, 32'h38, 32'h0, 3, 1'b0, 0);

    // reset in the middle of a stalled write ACCESS
    next_waits = 0;
    stuck      = 1'b1;
    @(negedge clk);
    bus.I_CMD_VALID = 1'b1;
    bus.I_CMD_WRITE = 1'b1;
    bus.I_CMD_ADDR  = 32'h20;
    bus.I_CMD_WDATA = 32'hA5A55A5A;
    @(negedge clk);
    bus.I_CMD_VALID = 1'b0;
    @(negedge clk);
    check("pre_reset_access", 32'(bus.O_PSEL & bus.O_PENABLE), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("async_psel", 32'(bus.O_PSEL), 32'd0);
    check("async_penable", 32'(bus.O_PENABLE), 32'd0);
    check("async_rsp_valid", 32'(bus.O_RSP_VALID), 32'd0);
    check("async_cmd_ready", 32'(bus.O_CMD_READY), 32'd0);
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_ready_before_edge", 32'(bus.O_CMD_READY), 32'd0);
    @(negedge clk);
    check("rel_ready_after_edge", 32'(bus.O_CMD_READY), 32'd1);
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.O_RSP_VALID || bus.O_PSEL) quiet++;
    end
    check("no_rsp_after_reset", quiet, 0);
    run_cmd(1'b0, 32'h20, 32'h0, 0, 1'b0, 0);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       addr = 32'(4 * $urandom_range(0, 14));
      else if (sel == 6) addr = 32'(4 * $urandom_range(0, 14) + $urandom_range(1, 3));
      else if (sel == 7) addr = 32'(LIMIT + 4 * $urandom_range(0, 3));
      else if (sel == 8) addr = $urandom;
      else               addr = 32'(LIMIT - 4);
      wr    = 1'($urandom_range(0, 1));
      waits = $urandom_range(0, 3);
      stk   = ($urandom_range(0, 7) == 0);
      hold  = $urandom_range(0, 3);
      run_cmd(wr, addr, $urandom, waits, stk, hold);
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
